// File: rtl/multicycle_control_fsm.sv
// Main controller of the RV32I multicycle datapath.
// Sequences fetch/decode/execute and drives datapath selects.
module multicycle_control_fsm #(
  parameter logic [3:0] ALU_AND = 4'b0000,
  parameter logic [3:0] ALU_OR  = 4'b0001,
  parameter logic [3:0] ALU_ADD = 4'b0010,
  parameter logic [3:0] ALU_SUB = 4'b0110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic [3:0] alu_control,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] fn_ctl;
  logic       fn_bad;

  assign state = state_q;

  // State register; reset returns to FETCH at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // ALU operation for R/I-type execute states
  always_comb begin
    fn_ctl = ALU_ADD;
    fn_bad = 1'b0;
    case (funct3)
      3'b000: fn_ctl = (state_q == S_EXECR && funct7b5)
                       ? ALU_SUB : ALU_ADD;
      3'b111: fn_ctl = ALU_AND;
      3'b110: fn_ctl = ALU_OR;
      default: fn_bad = 1'b1;
    endcase
  end

  // Next state and datapath controls, all forced quiet in reset
  always_comb begin
    state_d     = S_FETCH;
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    reg_write   = 1'b0;
    alu_control = ALU_AND;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        result_src  = 2'b10;
        ir_write    = mem_ready;
        pc_write    = mem_ready;
        state_d     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        case (op)
          7'b0000011: state_d = S_MEMADR;
          7'b0100011: state_d = S_MEMADR;
          7'b0110011: state_d = S_EXECR;
          7'b0010011: state_d = S_EXECI;
          7'b1100011: state_d = S_BEQ;
          7'b1101111: state_d = S_JAL;
          default:    illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        state_d     = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_control = fn_ctl;
        illegal     = fn_bad;
        state_d     = fn_bad ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        illegal     = (funct3 != 3'b000);
        pc_write    = zero && (funct3 == 3'b000);
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        pc_write    = 1'b1;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
    if (!rst_n) begin
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      reg_write   = 1'b0;
      alu_control = ALU_ADD;
      illegal     = 1'b0;
    end
  end

endmodule
